// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the instruction stage sequencer.
//   TX_CMD_BITS  : width of one TX command header
//   TX_HDR_*     : TX header encodings used by decode when building stage_cmd
//   seq_state_e  : sequencer FSM state encoding
package stage_sequencer_pkg;

    localparam int unsigned TX_CMD_BITS = 8;

    localparam logic [TX_CMD_BITS-1:0] TX_HDR_NOP   = 8'h00;
    localparam logic [TX_CMD_BITS-1:0] TX_HDR_READ  = 8'h01;
    localparam logic [TX_CMD_BITS-1:0] TX_HDR_WRITE = 8'h02;

    typedef enum logic [1:0] {
        SeqIdle = 2'd0,
        SeqImm  = 2'd1,
        SeqRun  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/stage_sequencer_read_credit_counter.sv
// Read credit counter: tracks reads issued but not yet answered.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc        : a read was issued this cycle (ignored when full)
//   dec        : a reply completed this cycle (ignored when empty)
//   count      : reads currently in flight
//   full       : count == MAX_OUTSTANDING
//   empty      : count == 0
//   underflow  : dec while empty (a reply nobody asked for)
module read_credit_counter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned OB = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [OB-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          underflow
);

    logic [OB-1:0] count_q, count_d;
    logic          up, down;

    assign full      = (count_q == OB'(MAX_OUTSTANDING));
    assign empty     = (count_q == '0);
    assign underflow = dec && empty;
    assign count     = count_q;

    // Both directions are qualified against the pre-update count, so an
    // issue and a retire in the same cycle cancel out.
    assign up   = inc && !full;
    assign down = dec && !empty;

    always_comb begin
        count_d = count_q;
        if (up && !down) begin
            count_d = count_q + 1'b1;
        end else if (down && !up) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Instruction stage sequencer: loads immediates, then walks an instruction
// through up to MAX_STAGES stages, handshaking TX commands, RX replies and
// the serial ALU. Only sequencing lives here; datapath muxing is external.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   inst_valid/inst_done  : instruction present / one-cycle retire pulse
//   last_stage            : index of the final stage
//   stage_send/read/wait  : per-stage TX issue, read, RX-consume flags
//   stage_cmd             : per-stage TX header, stage k at slice k
//   imm_words/load_imm/imm_loaded : immediate word load handshake
//   skip                  : condition failed, retire without running stages
//   stage                 : current stage index
//   alu_en/op_done        : ALU advance enable / stage finished
//   tx_command_valid/tx_command/tx_command_started/tx_data_next : TX link
//   rx_data_valid/rx_done : RX reply data / last reply cycle
//   outstanding           : reads in flight
//   protocol_error        : sticky, reply arrived with nothing in flight
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned MAX_STAGES      = 4,
    parameter int unsigned IMM_WORDS       = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned SB = $clog2(MAX_STAGES),
    localparam int unsigned IB = $clog2(IMM_WORDS + 1),
    localparam int unsigned OB = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            inst_valid,
    output logic                            inst_done,
    input  logic [SB-1:0]                   last_stage,
    input  logic [MAX_STAGES-1:0]           stage_send,
    input  logic [MAX_STAGES-1:0]           stage_read,
    input  logic [MAX_STAGES-1:0]           stage_wait,
    input  logic [MAX_STAGES*TX_CMD_BITS-1:0] stage_cmd,
    input  logic [IB-1:0]                   imm_words,
    output logic                            load_imm,
    input  logic                            imm_loaded,
    input  logic                            skip,
    output logic [SB-1:0]                   stage,
    output logic                            alu_en,
    input  logic                            op_done,
    output logic                            tx_command_valid,
    output logic [TX_CMD_BITS-1:0]          tx_command,
    input  logic                            tx_command_started,
    input  logic                            tx_data_next,
    input  logic                            rx_data_valid,
    input  logic                            rx_done,
    output logic [OB-1:0]                   outstanding,
    output logic                            protocol_error
);

    seq_state_e    state_q, state_d;
    logic [SB-1:0] stage_q, stage_d;
    logic [IB-1:0] imm_cnt_q, imm_cnt_d;
    logic          cmd_started_q, cmd_started_d;
    logic          protocol_error_q;

    logic cur_send, cur_read, cur_wait;
    logic rd_full, rd_empty, rd_underflow, rd_issue;

    assign cur_send = stage_send[stage_q];
    assign cur_read = stage_read[stage_q];
    assign cur_wait = stage_wait[stage_q];

    assign stage          = stage_q;
    assign tx_command     = stage_cmd[stage_q*TX_CMD_BITS +: TX_CMD_BITS];
    assign protocol_error = protocol_error_q;

    // Only reads accepted while running consume a credit.
    assign rd_issue = (state_q == SeqRun) && tx_command_started && cur_read;

    read_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credits (
        .clk       (clk),
        .reset     (reset),
        .inc       (rd_issue),
        .dec       (rx_done),
        .count     (outstanding),
        .full      (rd_full),
        .empty     (rd_empty),
        .underflow (rd_underflow)
    );

    always_comb begin
        state_d          = state_q;
        stage_d          = stage_q;
        imm_cnt_d        = imm_cnt_q;
        cmd_started_d    = cmd_started_q;
        inst_done        = 1'b0;
        load_imm         = 1'b0;
        alu_en           = 1'b0;
        tx_command_valid = 1'b0;

        unique case (state_q)
            SeqIdle: begin
                if (inst_valid) begin
                    if (imm_words != '0) begin
                        state_d   = SeqImm;
                        imm_cnt_d = imm_words;
                    end else if (skip) begin
                        inst_done = 1'b1;
                    end else begin
                        state_d       = SeqRun;
                        stage_d       = '0;
                        cmd_started_d = 1'b0;
                    end
                end
            end

            SeqImm: begin
                load_imm = 1'b1;
                if (imm_loaded) begin
                    if (imm_cnt_q > IB'(1)) begin
                        imm_cnt_d = imm_cnt_q - 1'b1;
                    end else begin
                        // Last word: skip is only meaningful from here on.
                        imm_cnt_d = '0;
                        if (skip) begin
                            inst_done = 1'b1;
                            state_d   = SeqIdle;
                        end else begin
                            state_d       = SeqRun;
                            stage_d       = '0;
                            cmd_started_d = 1'b0;
                        end
                    end
                end
            end

            SeqRun: begin
                // Hold a read at full credits, and a reply-consuming command
                // until something is actually in flight.
                tx_command_valid = cur_send && !cmd_started_q &&
                                   !(cur_read && rd_full) && !(cur_wait && rd_empty);
                alu_en = !(cur_send && !(cmd_started_q && tx_data_next)) &&
                         !(cur_wait && !rx_data_valid);
                if (tx_command_started) begin
                    cmd_started_d = 1'b1;
                end
                if (op_done) begin
                    cmd_started_d = 1'b0;
                    if (stage_q == last_stage) begin
                        inst_done = 1'b1;
                        state_d   = SeqIdle;
                        stage_d   = '0;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = SeqIdle;
                stage_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= SeqIdle;
            stage_q          <= '0;
            imm_cnt_q        <= '0;
            cmd_started_q    <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            imm_cnt_q     <= imm_cnt_d;
            cmd_started_q <= cmd_started_d;
            if (rd_underflow) begin
                protocol_error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: reset check, a directed per-cycle vector table,
// hand sequences for sticky protocol_error and mid-instruction reset, then
// randomized instructions checked against a transaction-level model.
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    localparam int unsigned MS = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned MO = 2;
    localparam int unsigned SB = 2;
    localparam int unsigned IB = 2;
    localparam int unsigned OB = 2;
    localparam int unsigned CB = TX_CMD_BITS;

    logic            clk = 1'b0;
    logic            reset;
    logic            inst_valid, inst_done;
    logic [SB-1:0]   last_stage;
    logic [MS-1:0]   stage_send, stage_read, stage_wait;
    logic [MS*CB-1:0] stage_cmd;
    logic [IB-1:0]   imm_words;
    logic            load_imm, imm_loaded, skip;
    logic [SB-1:0]   stage;
    logic            alu_en, op_done, tx_command_valid;
    logic [CB-1:0]   tx_command;
    logic            tx_command_started, tx_data_next, rx_data_valid, rx_done;
    logic [OB-1:0]   outstanding;
    logic            protocol_error;

    always #5 clk = ~clk;

    stage_sequencer #(
        .MAX_STAGES      (MS),
        .IMM_WORDS       (IW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .inst_valid         (inst_valid),
        .inst_done          (inst_done),
        .last_stage         (last_stage),
        .stage_send         (stage_send),
        .stage_read         (stage_read),
        .stage_wait         (stage_wait),
        .stage_cmd          (stage_cmd),
        .imm_words          (imm_words),
        .load_imm           (load_imm),
        .imm_loaded         (imm_loaded),
        .skip               (skip),
        .stage              (stage),
        .alu_en             (alu_en),
        .op_done            (op_done),
        .tx_command_valid   (tx_command_valid),
        .tx_command         (tx_command),
        .tx_command_started (tx_command_started),
        .tx_data_next       (tx_data_next),
        .rx_data_valid      (rx_data_valid),
        .rx_done            (rx_done),
        .outstanding        (outstanding),
        .protocol_error     (protocol_error)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic cmp(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", tag, what, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_done, input logic e_load,
                              input logic [SB-1:0] e_stage, input logic e_alu,
                              input logic e_valid, input logic [OB-1:0] e_os,
                              input logic e_pe);
        logic [CB-1:0] e_cmd;
        e_cmd = stage_cmd[e_stage*CB +: CB];
        cmp(tag, "inst_done",        32'(inst_done),        32'(e_done));
        cmp(tag, "load_imm",         32'(load_imm),         32'(e_load));
        cmp(tag, "stage",            32'(stage),            32'(e_stage));
        cmp(tag, "alu_en",           32'(alu_en),           32'(e_alu));
        cmp(tag, "tx_command_valid", 32'(tx_command_valid), 32'(e_valid));
        cmp(tag, "tx_command",       32'(tx_command),       32'(e_cmd));
        cmp(tag, "outstanding",      32'(outstanding),      32'(e_os));
        cmp(tag, "protocol_error",   32'(protocol_error),   32'(e_pe));
    endtask

    task automatic idle_inputs();
        inst_valid = 1'b0; imm_loaded = 1'b0; skip = 1'b0; op_done = 1'b0;
        tx_command_started = 1'b0; tx_data_next = 1'b0;
        rx_data_valid = 1'b0; rx_done = 1'b0;
        last_stage = '0; stage_send = '0; stage_read = '0; stage_wait = '0;
        imm_words = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Directed table: each row is one clock cycle of inputs plus the
    // combinational outputs expected in that cycle.
    typedef struct {
        int         cfg;
        logic       iv, il, sk, od, ts, tn, rv, rxd;
        logic       dn, li;
        logic [1:0] st;
        logic       ae, tv;
        logic [1:0] os;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int c, input logic [7:0] in_b, input logic [1:0] dl,
                       input logic [1:0] st, input logic [1:0] at, input logic [1:0] os);
        vec_t v;
        v.cfg = c;
        {v.iv, v.il, v.sk, v.od, v.ts, v.tn, v.rv, v.rxd} = in_b;
        {v.dn, v.li} = dl;
        v.st = st;
        {v.ae, v.tv} = at;
        v.os = os;
        tbl.push_back(v);
    endtask

    task automatic set_cfg(input int c);
        case (c)
            0: begin last_stage = 2'd0; stage_send = 4'b0000; stage_read = 4'b0000;
                     stage_wait = 4'b0000; imm_words = 2'd2; end
            1: begin last_stage = 2'd0; stage_send = 4'b0000; stage_read = 4'b0000;
                     stage_wait = 4'b0000; imm_words = 2'd1; end
            2: begin last_stage = 2'd1; stage_send = 4'b0001; stage_read = 4'b0001;
                     stage_wait = 4'b0010; imm_words = 2'd0; end
            default: begin last_stage = 2'd2; stage_send = 4'b0111; stage_read = 4'b0111;
                     stage_wait = 4'b0000; imm_words = 2'd0; end
        endcase
    endtask

    // Reference model: instruction phase, immediates left, stage, and the
    // list of reads awaiting replies (oldest first).
    int   m_ph, m_imm, m_stage, m_tag;
    bit   m_started, m_err;
    int   m_q[$];
    bit   e_done, e_load, e_alu, e_valid;
    int   e_stage, e_os;

    task automatic model_reset();
        m_ph = 0; m_imm = 0; m_stage = 0; m_started = 0; m_err = 0; m_tag = 0;
        m_q.delete();
    endtask

    task automatic model_eval();
        bit run;
        int k;
        run = (m_ph == 2);
        k = m_stage;
        e_load  = (m_ph == 1);
        e_stage = k;
        e_os    = m_q.size();
        e_valid = run && stage_send[k] && !m_started &&
                  !(stage_read[k] && e_os == int'(MO)) && !(stage_wait[k] && e_os == 0);
        e_alu   = run && !(stage_send[k] && !(m_started && tx_data_next)) &&
                  !(stage_wait[k] && !rx_data_valid);
        e_done  = (m_ph == 0 && inst_valid && imm_words == '0 && skip) ||
                  (m_ph == 1 && imm_loaded && m_imm == 1 && skip) ||
                  (run && op_done && k == int'(last_stage));
    endtask

    task automatic model_update();
        bit issue;
        int k;
        k = m_stage;
        issue = (m_ph == 2) && tx_command_started && stage_read[k] && m_q.size() < int'(MO);
        if (rx_done) begin
            if (m_q.size() == 0) m_err = 1;
            else void'(m_q.pop_front());
        end
        if (issue) begin
            m_q.push_back(m_tag);
            m_tag++;
        end
        case (m_ph)
            0: if (inst_valid) begin
                if (imm_words != '0) begin
                    m_ph = 1; m_imm = int'(imm_words);
                end else if (!skip) begin
                    m_ph = 2; m_stage = 0; m_started = 0;
                end
            end
            1: if (imm_loaded) begin
                m_imm--;
                if (m_imm == 0) begin
                    if (skip) m_ph = 0;
                    else begin m_ph = 2; m_stage = 0; m_started = 0; end
                end
            end
            default: begin
                if (op_done) begin
                    m_started = 0;
                    if (k == int'(last_stage)) begin m_ph = 0; m_stage = 0; end
                    else m_stage++;
                end else if (tx_command_started) begin
                    m_started = 1;
                end
            end
        endcase
    endtask

    initial begin
        bit have_inst;
        reset = 1'b1;
        idle_inputs();
        stage_cmd = 32'hD4C3_B2A1;

        // cfg  {iv il sk od ts tn rv rxd} {dn li} st {ae tv} os
        add(0, 8'b1000_0000, 2'b00, 2'd0, 2'b00, 2'd0);
        add(0, 8'b1000_0000, 2'b01, 2'd0, 2'b00, 2'd0);
        add(0, 8'b1100_0000, 2'b01, 2'd0, 2'b00, 2'd0);
        add(0, 8'b1100_0000, 2'b01, 2'd0, 2'b00, 2'd0);
        add(0, 8'b1000_0000, 2'b00, 2'd0, 2'b10, 2'd0);
        add(0, 8'b1001_0000, 2'b10, 2'd0, 2'b10, 2'd0);
        add(0, 8'b0100_0000, 2'b00, 2'd0, 2'b00, 2'd0);
        add(1, 8'b1010_0000, 2'b00, 2'd0, 2'b00, 2'd0);
        add(1, 8'b1110_0000, 2'b11, 2'd0, 2'b00, 2'd0);
        add(1, 8'b0000_0000, 2'b00, 2'd0, 2'b00, 2'd0);
        add(2, 8'b1000_0000, 2'b00, 2'd0, 2'b00, 2'd0);
        add(2, 8'b1000_1000, 2'b00, 2'd0, 2'b01, 2'd0);
        add(2, 8'b1001_0100, 2'b00, 2'd0, 2'b10, 2'd1);
        add(2, 8'b1000_0000, 2'b00, 2'd1, 2'b00, 2'd1);
        add(2, 8'b1001_0011, 2'b10, 2'd1, 2'b10, 2'd1);
        add(2, 8'b0000_0000, 2'b00, 2'd0, 2'b00, 2'd0);
        add(3, 8'b1000_0000, 2'b00, 2'd0, 2'b00, 2'd0);
        add(3, 8'b1000_1000, 2'b00, 2'd0, 2'b01, 2'd0);
        add(3, 8'b1001_0100, 2'b00, 2'd0, 2'b10, 2'd1);
        add(3, 8'b1000_1000, 2'b00, 2'd1, 2'b01, 2'd1);
        add(3, 8'b1001_0100, 2'b00, 2'd1, 2'b10, 2'd2);
        add(3, 8'b1000_0000, 2'b00, 2'd2, 2'b00, 2'd2);
        add(3, 8'b1000_0001, 2'b00, 2'd2, 2'b00, 2'd2);
        add(3, 8'b1000_1001, 2'b00, 2'd2, 2'b01, 2'd1);
        add(3, 8'b1001_0100, 2'b10, 2'd2, 2'b10, 2'd1);
        add(3, 8'b0000_0001, 2'b00, 2'd0, 2'b00, 2'd1);
        add(3, 8'b0000_0000, 2'b00, 2'd0, 2'b00, 2'd0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outs("reset", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        foreach (tbl[i]) begin
            set_cfg(tbl[i].cfg);
            {inst_valid, imm_loaded, skip, op_done} = {tbl[i].iv, tbl[i].il, tbl[i].sk, tbl[i].od};
            {tx_command_started, tx_data_next} = {tbl[i].ts, tbl[i].tn};
            {rx_data_valid, rx_done} = {tbl[i].rv, tbl[i].rxd};
            #1;
            check_outs($sformatf("tbl[%0d]", i), tbl[i].dn, tbl[i].li, tbl[i].st,
                       tbl[i].ae, tbl[i].tv, tbl[i].os, 1'b0);
            next_cycle();
        end

        // Stray reply with nothing in flight: error is sticky until reset.
        idle_inputs();
        rx_done = 1'b1;
        #1;
        check_outs("perr_pulse", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        next_cycle();
        rx_done = 1'b0;
        repeat (3) begin
            #1;
            check_outs("perr_sticky", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        check_outs("perr_cleared", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Reset in stage 2 with one read in flight.
        last_stage = 2'd3; stage_send = 4'b0001; stage_read = 4'b0001; stage_wait = 4'b0000;
        imm_words = 2'd0; inst_valid = 1'b1;
        next_cycle();
        tx_command_started = 1'b1;
        next_cycle();
        tx_command_started = 1'b0; tx_data_next = 1'b1; op_done = 1'b1;
        next_cycle();
        next_cycle();
        op_done = 1'b0;
        #1;
        check_outs("pre_reset", 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 2'd1, 1'b0);
        reset = 1'b1;
        inst_valid = 1'b0;
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        #1;
        check_outs("mid_reset", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Randomized instructions against the model.
        model_reset();
        have_inst = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!have_inst) begin
                if ($urandom % 3 == 0) begin
                    inst_valid = 1'b0;
                end else begin
                    last_stage = SB'($urandom);
                    stage_send = MS'($urandom);
                    stage_read = MS'($urandom);
                    stage_wait = MS'($urandom);
                    imm_words  = IB'($urandom_range(0, IW));
                    skip       = ($urandom % 4 == 0);
                    inst_valid = 1'b1;
                    have_inst  = 1;
                end
            end
            imm_loaded    = ($urandom % 3 == 0);
            op_done       = ($urandom % 3 == 0);
            tx_data_next  = ($urandom % 2 == 0);
            rx_data_valid = ($urandom % 2 == 0);
            rx_done       = (m_q.size() > 0) && ($urandom % 4 == 0);
            tx_command_started = 1'b0;
            model_eval();
            tx_command_started = e_valid && ($urandom % 2 == 0);
            #1;
            check_outs("rnd", e_done, e_load, SB'(e_stage), e_alu, e_valid, OB'(e_os), m_err);
            if (e_done) have_inst = 0;
            model_update();
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
